// File: rtl/ghost_sprite_mux.sv
// Multi-ghost sprite renderer: per-frame shadowed positions, fixed-priority overlap, frightened flash.
// Optional eyes overlay enabled by defining GHOST_EYES_EN; the default build draws solid boxes.
module ghost_sprite_mux #(
  parameter int          NUM_GHOSTS   = 4,
  parameter int          COORD_W      = 9,
  parameter int          SPRITE_W     = 14,
  parameter int          SPRITE_H     = 14,
  parameter int          FLASH_FRAMES = 16,
  parameter logic [11:0] FRIGHT_COLOR = 12'h22F,
  parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
  input  logic [NUM_GHOSTS*12-1:0]      ghost_color,
  input  logic [NUM_GHOSTS-1:0]         ghost_en,
  input  logic                          frightened,
  input  logic                          de,
  input  logic [COORD_W-1:0]            sx,
  input  logic [COORD_W-1:0]            sy,
  output logic [3:0]                    R,
  output logic [3:0]                    G,
  output logic [3:0]                    B,
  output logic                          de_out,
  output logic                          hit,
  output logic [2:0]                    hit_id
);

  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [COORD_W:0] SW = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0] SH = (COORD_W+1)'(SPRITE_H);

  logic [NUM_GHOSTS*COORD_W-1:0] sh_x, sh_y;
  logic [NUM_GHOSTS*12-1:0]      sh_col;
  logic [NUM_GHOSTS-1:0]         sh_en;
  logic [CNT_W-1:0]              flash_cnt;
  logic                          flash_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_col <= '0;
      sh_en  <= '0;
    end else if (frame_start) begin
      sh_x   <= ghost_x;
      sh_y   <= ghost_y;
      sh_col <= ghost_color;
      sh_en  <= ghost_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !frightened) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      if (flash_cnt == CNT_LAST) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

  // Stage 1: coverage in COORD_W+1 bits so a sprite near the right/bottom edge never wraps.
  logic [NUM_GHOSTS-1:0] cover_c, s1_cover;
  logic                  s1_de;
`ifdef GHOST_EYES_EN
  logic [COORD_W:0] rel_x_c [NUM_GHOSTS];
  logic [COORD_W:0] rel_y_c [NUM_GHOSTS];
  logic [COORD_W:0] s1_rel_x [NUM_GHOSTS];
  logic [COORD_W:0] s1_rel_y [NUM_GHOSTS];
`endif

  always_comb begin
    cover_c = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      cover_c[i] = sh_en[i]
        && ({1'b0, sx} >= {1'b0, sh_x[i*COORD_W +: COORD_W]})
        && ({1'b0, sx} <  {1'b0, sh_x[i*COORD_W +: COORD_W]} + SW)
        && ({1'b0, sy} >= {1'b0, sh_y[i*COORD_W +: COORD_W]})
        && ({1'b0, sy} <  {1'b0, sh_y[i*COORD_W +: COORD_W]} + SH);
`ifdef GHOST_EYES_EN
      rel_x_c[i] = {1'b0, sx} - {1'b0, sh_x[i*COORD_W +: COORD_W]};
      rel_y_c[i] = {1'b0, sy} - {1'b0, sh_y[i*COORD_W +: COORD_W]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_cover <= '0;
      s1_de    <= 1'b0;
`ifdef GHOST_EYES_EN
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        s1_rel_x[i] <= '0;
        s1_rel_y[i] <= '0;
      end
`endif
    end else begin
      s1_cover <= cover_c;
      s1_de    <= de;
`ifdef GHOST_EYES_EN
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        s1_rel_x[i] <= rel_x_c[i];
        s1_rel_y[i] <= rel_y_c[i];
      end
`endif
    end
  end

  // Stage 2: descending scan so the lowest covering index is the one left standing.
  logic [2:0]  win_id;
  logic        win_hit;
  logic [11:0] win_col;
  logic        win_eye;
  logic [11:0] pix_col;

  always_comb begin
    win_id  = '0;
    win_hit = 1'b0;
    win_col = '0;
    win_eye = 1'b0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      if (s1_cover[i]) begin
        win_id  = 3'(i);
        win_hit = 1'b1;
        win_col = sh_col[i*12 +: 12];
`ifdef GHOST_EYES_EN
        win_eye = ((s1_rel_y[i] == (COORD_W+1)'(3)) || (s1_rel_y[i] == (COORD_W+1)'(4)))
          && ((s1_rel_x[i] == (COORD_W+1)'(3)) || (s1_rel_x[i] == (COORD_W+1)'(4))
           || (s1_rel_x[i] == (COORD_W+1)'(SPRITE_W - 5))
           || (s1_rel_x[i] == (COORD_W+1)'(SPRITE_W - 4)));
`else
        win_eye = 1'b0;
`endif
      end
    end
    if (frightened) pix_col = flash_phase ? FLASH_COLOR : FRIGHT_COLOR;
    else            pix_col = win_col;
    if (win_eye) pix_col = 12'hFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {R, G, B} <= '0;
      de_out    <= 1'b0;
      hit       <= 1'b0;
      hit_id    <= '0;
    end else begin
      de_out <= s1_de;
      if (s1_de && win_hit) begin
        {R, G, B} <= pix_col;
        hit       <= 1'b1;
        hit_id    <= win_id;
      end else begin
        {R, G, B} <= '0;
        hit       <= 1'b0;
        hit_id    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ghost_sprite_mux.sv
// Bench for ghost_sprite_mux: per-cycle reference model comparison plus directed literal pixel checks.
module tb_ghost_sprite_mux;
  localparam int NG = 4, CW = 9, SW = 14, SH = 14, FF = 2;

  logic clk = 1'b0;
  logic rst, frame_start, frightened, de;
  logic [CW-1:0] sx, sy;
  logic [NG*CW-1:0] ghost_x, ghost_y;
  logic [NG*12-1:0] ghost_color;
  logic [NG-1:0] ghost_en;
  logic [3:0] R, G, B;
  logic de_out, hit;
  logic [2:0] hit_id;

  int total = 0, passed = 0;

  ghost_sprite_mux #(.NUM_GHOSTS(NG), .COORD_W(CW), .SPRITE_W(SW), .SPRITE_H(SH),
                     .FLASH_FRAMES(FF), .FRIGHT_COLOR(12'h22F), .FLASH_COLOR(12'hFFF)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .ghost_color(ghost_color), .ghost_en(ghost_en), .frightened(frightened), .de(de),
    .sx(sx), .sy(sy), .R(R), .G(G), .B(B), .de_out(de_out), .hit(hit), .hit_id(hit_id));

  always #5 clk = ~clk;

  // Reference model: shadows as int arrays, flash phase derived from the number of frightened frames.
  int m_x[NG], m_y[NG], m_col[NG];
  bit m_en[NG];
  int n_fr;
  bit p1_de, p1_hit, p1_eye;
  int p1_id, p1_col;
  bit e_de, e_hit;
  int e_id, e_rgb;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NG; i++) begin m_x[i] = 0; m_y[i] = 0; m_col[i] = 0; m_en[i] = 0; end
      n_fr = 0; p1_de = 0; p1_hit = 0; p1_eye = 0; p1_id = 0; p1_col = 0;
      e_de = 0; e_hit = 0; e_id = 0; e_rgb = 0;
      chk_en = 1'b1;
    end else begin
      e_de = p1_de;
      if (p1_de && p1_hit) begin
        e_hit = 1; e_id = p1_id;
        if (!frightened) e_rgb = p1_col;
        else e_rgb = (((n_fr / FF) % 2) == 1) ? 'hFFF : 'h22F;
        if (p1_eye) e_rgb = 'hFFF;
      end else begin
        e_hit = 0; e_id = 0; e_rgb = 0;
      end
      p1_de = de; p1_hit = 0; p1_id = 0; p1_col = 0; p1_eye = 0;
      for (int i = 0; i < NG; i++) begin
        if (!p1_hit && m_en[i] && int'(sx) >= m_x[i] && int'(sx) < m_x[i] + SW
            && int'(sy) >= m_y[i] && int'(sy) < m_y[i] + SH) begin
          p1_hit = 1; p1_id = i; p1_col = m_col[i];
`ifdef GHOST_EYES_EN
          begin
            int rx, ry;
            rx = int'(sx) - m_x[i];
            ry = int'(sy) - m_y[i];
            p1_eye = (ry == 3 || ry == 4) && (rx == 3 || rx == 4 || rx == SW - 5 || rx == SW - 4);
          end
`endif
        end
      end
      if (frame_start)
        for (int i = 0; i < NG; i++) begin
          m_x[i] = int'(ghost_x[i*CW +: CW]);
          m_y[i] = int'(ghost_y[i*CW +: CW]);
          m_col[i] = int'(ghost_color[i*12 +: 12]);
          m_en[i] = ghost_en[i];
        end
      if (!frightened) n_fr = 0;
      else if (frame_start) n_fr++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({R, G, B} === 12'(e_rgb) && de_out === e_de && hit === e_hit && hit_id === 3'(e_id))
        passed++;
      else
        $display("FAIL model t=%0t: got rgb=%h de=%b hit=%b id=%0d want rgb=%h de=%b hit=%b id=%0d",
                 $time, {R, G, B}, de_out, hit, hit_id, 12'(e_rgb), e_de, e_hit, e_id);
    end
  end

  task automatic lit(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got rgb=%h de/hit/id=%b want rgb=%h de/hit/id=%b",
                  name, act[16:5], act[4:0], exp[16:5], exp[4:0]);
  endtask

  task automatic px(input string name, input int x, input int y, input bit d,
                    input logic [11:0] rgb, input bit h, input logic [2:0] id);
    @(negedge clk); sx = CW'(x); sy = CW'(y); de = d;
    @(posedge clk); @(posedge clk); #1;
    lit(name, {R, G, B, de_out, hit, hit_id}, {rgb, d, h, id});
  endtask

  task automatic frame();
    @(negedge clk); de = 1'b0; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic set_ghost(input int i, input int x, input int y, input logic [11:0] c);
    ghost_x[i*CW +: CW] = CW'(x);
    ghost_y[i*CW +: CW] = CW'(y);
    ghost_color[i*12 +: 12] = c;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; frightened = 1'b0; de = 1'b0; sx = '0; sy = '0;
    ghost_x = '0; ghost_y = '0; ghost_color = '0; ghost_en = 4'b0001;
    set_ghost(0, 10, 20, 12'hE11);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    px("pre_frame_origin", 10, 20, 1, 12'h000, 0, 0);
    px("pre_frame_inside", 15, 25, 1, 12'h000, 0, 0);
    frame();
    px("first_pixel", 10, 20, 1, 12'hE11, 1, 0);
    px("last_inside", 23, 33, 1, 12'hE11, 1, 0);
    px("right_excl", 24, 20, 1, 12'h000, 0, 0);
    px("bottom_excl", 10, 34, 1, 12'h000, 0, 0);
    px("left_outside", 9, 20, 1, 12'h000, 0, 0);

    set_ghost(1, 50, 50, 12'h0F0);
    set_ghost(3, 50, 50, 12'hF0F);
    ghost_en = 4'b1011;
    frame();
    px("priority_1_over_3", 55, 55, 1, 12'h0F0, 1, 1);

    set_ghost(0, 100, 20, 12'hE11);
    px("shadow_old_pos", 10, 20, 1, 12'hE11, 1, 0);
    px("shadow_new_not_yet", 100, 20, 1, 12'h000, 0, 0);
    frame();
    px("shadow_old_gone", 10, 20, 1, 12'h000, 0, 0);
    px("shadow_new_pos", 100, 20, 1, 12'hE11, 1, 0);

    @(negedge clk); frightened = 1'b1;
    px("fright_f0", 100, 20, 1, 12'h22F, 1, 0);
    frame(); px("fright_f1", 100, 20, 1, 12'h22F, 1, 0);
    frame(); px("fright_f2", 100, 20, 1, 12'hFFF, 1, 0);
    frame(); px("fright_f3", 100, 20, 1, 12'hFFF, 1, 0);
    frame(); px("fright_f4", 100, 20, 1, 12'h22F, 1, 0);
    frame();
    @(negedge clk); frightened = 1'b0;
    px("fright_drop", 100, 20, 1, 12'hE11, 1, 0);
    @(negedge clk); frightened = 1'b1;
    frame(); px("fright_restart_f1", 100, 20, 1, 12'h22F, 1, 0);
    frame(); px("fright_restart_f2", 100, 20, 1, 12'hFFF, 1, 0);
    @(negedge clk); frightened = 1'b0;

    set_ghost(0, 511, 20, 12'hE11);
    frame();
    px("edge_511", 511, 20, 1, 12'hE11, 1, 0);
    px("edge_510", 510, 20, 1, 12'h000, 0, 0);
    px("edge_nowrap_0", 0, 20, 1, 12'h000, 0, 0);
    px("edge_nowrap_12", 12, 20, 1, 12'h000, 0, 0);
    px("de_low", 511, 20, 0, 12'h000, 0, 0);

    @(negedge clk); sx = CW'(511); sy = CW'(20); de = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    lit("rst_midline", {R, G, B, de_out, hit, hit_id}, 17'd0);
    @(negedge clk); rst = 1'b0;
    px("post_rst_no_draw", 511, 20, 1, 12'h000, 0, 0);

`ifdef GHOST_EYES_EN
    set_ghost(0, 0, 0, 12'hE11);
    ghost_en = 4'b0001;
    frame();
    px("eye_left", 3, 3, 1, 12'hFFF, 1, 0);
    px("eye_right", 9, 4, 1, 12'hFFF, 1, 0);
    px("eye_body", 6, 6, 1, 12'hE11, 1, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
